// File: rtl/wb_trace_tx.sv
// wb_trace_tx: buffers write-back events in a show-ahead FIFO and streams them out with sequence numbers.
// Optional TRACE_FILTER_X0_EN drops x0 writes before they are sequenced or stored.
module wb_trace_tx #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int DEPTH     = 8,
    parameter int SEQ_W     = 8
) (
    input  logic                       CLK,
    input  logic                       CLEAR,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd,
    input  logic [DATA_SIZE-1:0]       wb_data,
    input  logic [ADDR_SIZE-1:0]       wb_pc,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [4:0]                 trace_rd,
    output logic [DATA_SIZE-1:0]       trace_data,
    output logic [ADDR_SIZE-1:0]       trace_pc,
    output logic [SEQ_W-1:0]           trace_seq,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]           rd_mem   [DEPTH];
    logic [DATA_SIZE-1:0] data_mem [DEPTH];
    logic [ADDR_SIZE-1:0] pc_mem   [DEPTH];
    logic [SEQ_W-1:0]     seq_mem  [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [SEQ_W-1:0]     seq;
    logic                 accept, full, pop, push;

`ifdef TRACE_FILTER_X0_EN
    assign accept = wb_valid && (wb_rd != 5'd0);
`else
    assign accept = wb_valid;
`endif
    assign full        = fill == FULL;
    assign trace_valid = fill != '0;
    assign pop         = trace_valid && trace_ready;
    // a pop on the same edge frees the slot, so a full FIFO can still take the event
    assign push        = accept && (!full || pop);

    assign trace_rd   = trace_valid ? rd_mem[rd_ptr]   : '0;
    assign trace_data = trace_valid ? data_mem[rd_ptr] : '0;
    assign trace_pc   = trace_valid ? pc_mem[rd_ptr]   : '0;
    assign trace_seq  = trace_valid ? seq_mem[rd_ptr]  : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            rd_mem[wr_ptr]   <= wb_rd;
            data_mem[wr_ptr] <= wb_data;
            pc_mem[wr_ptr]   <= wb_pc;
            seq_mem[wr_ptr]  <= seq;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept) seq <= seq + 1'b1;
            if (accept && !push) overflow <= 1'b1;
            fill <= (push && !pop) ? fill + 1'b1 : (pop && !push) ? fill - 1'b1 : fill;
        end
    end
endmodule
